reglist_transfer_seq: RTL and testbench

Multi-register transfer sequencer for the core's LDM/STM/PUSH/POP instructions. It sits between the decode stage, the 16-entry register file and the data-memory port. While busy it owns one register-file read port and the register-file write port. It walks a 16-bit register list one register per memory transfer, then optionally writes the updated base back.

---
 rtl/reglist_transfer_seq_if.sv | 43 ++++
 rtl/reglist_transfer_seq.sv | 136 +++++++++++++
 tb/tb_reglist_transfer_seq.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reglist_transfer_seq_if.sv
// Decode, register-file and data-memory signals of the multi-register transfer sequencer.
interface reglist_transfer_seq_if #(
   parameter int ADDR_W = 32
);
   logic              start;
   logic              is_load;
   logic              dec_before;
   logic              writeback;
   logic [3:0]        base_reg;
   logic [15:0]       reg_list;
   logic              busy;
   logic              done;
   logic              err;
   logic [3:0]        rf_raddr;
   logic [ADDR_W-1:0] rf_rdata;
   logic [3:0]        rf_waddr;
   logic [ADDR_W-1:0] rf_wdata;
   logic              rf_we;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [ADDR_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_rdata;

   modport slave (
      input  start, is_load, dec_before, writeback, base_reg, reg_list,
      output busy, done, err,
      output rf_raddr, input rf_rdata,
      output rf_waddr, rf_wdata, rf_we,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport master (
      output start, is_load, dec_before, writeback, base_reg, reg_list,
      input  busy, done, err,
      input  rf_raddr, output rf_rdata,
      input  rf_waddr, rf_wdata, rf_we,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/reglist_transfer_seq.sv
// LDM/STM/PUSH/POP sequencer: walks a register list one memory transfer per register,
// then optionally writes the updated base back.
module reglist_transfer_seq #(
   parameter int ADDR_W = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   reglist_transfer_seq_if.slave bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_BASE = 3'd1;
   localparam logic [2:0] S_XFER = 3'd2;
   localparam logic [2:0] S_WB   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]        state;
   logic              ld_q;
   logic              db_q;
   logic              wb_q;
   logic              empty_q;
   logic              base_in_list_q;
   logic [3:0]        base_reg_q;
   logic [15:0]       remaining;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] final_q;

   logic [3:0]        cur_idx;
   logic              found;
   logic [4:0]        n;
   logic [ADDR_W-1:0] four_n;
   logic [15:0]       rem_next;
   logic              last;

   always_comb begin
      cur_idx = '0;
      found   = 1'b0;
      n       = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         n = n + 5'(remaining[i]);
         if (remaining[i] && !found) begin
            cur_idx = 4'(i);
            found   = 1'b1;
         end
      end
   end

   assign four_n   = ADDR_W'({n, 2'b00});
   assign rem_next = remaining & (remaining - 16'd1);
   assign last     = (rem_next == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         ld_q           <= 1'b0;
         db_q           <= 1'b0;
         wb_q           <= 1'b0;
         empty_q        <= 1'b0;
         base_in_list_q <= 1'b0;
         base_reg_q     <= '0;
         remaining      <= '0;
         addr_q         <= '0;
         final_q        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  ld_q           <= bus.is_load;
                  db_q           <= bus.dec_before;
                  wb_q           <= bus.writeback;
                  base_reg_q     <= bus.base_reg;
                  remaining      <= bus.reg_list;
                  empty_q        <= (bus.reg_list == '0);
                  base_in_list_q <= bus.reg_list[bus.base_reg];
                  state          <= S_BASE;
               end
            end
            S_BASE: begin
               // Both directions ascend through memory; decrement-before just starts lower.
               addr_q  <= db_q ? bus.rf_rdata - four_n : bus.rf_rdata;
               final_q <= db_q ? bus.rf_rdata - four_n : bus.rf_rdata + four_n;
               state   <= empty_q ? S_DONE : S_XFER;
            end
            S_XFER: begin
               if (bus.mem_ready) begin
                  remaining <= rem_next;
                  addr_q    <= addr_q + ADDR_W'(4);
                  if (last) begin
                     // A loaded base register takes precedence over the writeback value.
                     state <= (wb_q && !(ld_q && base_in_list_q)) ? S_WB : S_DONE;
                  end
               end
            end
            S_WB:    state <= S_DONE;
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy      = (state != S_IDLE);
      bus.done      = (state == S_DONE);
      bus.err       = (state == S_DONE) && empty_q;
      bus.rf_raddr  = '0;
      bus.rf_waddr  = '0;
      bus.rf_wdata  = '0;
      bus.rf_we     = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state)
         S_BASE: bus.rf_raddr = base_reg_q;
         S_XFER: begin
            bus.rf_raddr  = cur_idx;
            bus.mem_req   = 1'b1;
            bus.mem_we    = !ld_q;
            bus.mem_addr  = addr_q;
            bus.mem_wdata = ld_q ? '0 : bus.rf_rdata;
            if (ld_q && bus.mem_ready) begin
               bus.rf_we    = 1'b1;
               bus.rf_waddr = cur_idx;
               bus.rf_wdata = bus.mem_rdata;
            end
         end
         S_WB: begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = base_reg_q;
            bus.rf_wdata = final_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_reglist_transfer_seq.sv
// Bench for reglist_transfer_seq: directed table, reset/wrap sequence and randomized commands
// checked against a list-level model of register file and memory traffic.
module tb_reglist_transfer_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reglist_transfer_seq_if #(.ADDR_W(32)) bus ();

   reglist_transfer_seq #(.ADDR_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned checks = 0;
   int unsigned failures = 0;

   logic [31:0] rf [16];
   logic        tb_we = 1'b0;
   logic [3:0]  tb_waddr = '0;
   logic [31:0] tb_wdata = '0;
   logic [31:0] mem [logic [31:0]];

   assign bus.rf_rdata = rf[bus.rf_raddr];

   always @(posedge clk) begin
      if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
      else if (tb_we) rf[tb_waddr] <= tb_wdata;
   end

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : ((a ^ 32'hC3A5_0000) + 32'h1);
   endfunction

   // Memory responder: per-beat random wait states, drives just after the clock edge.
   int unsigned stall_lo = 0;
   int unsigned stall_hi = 0;
   int unsigned stall_total = 0;
   int unsigned wait_cnt = 0;
   int unsigned beat_stall = 0;

   always @(posedge clk) begin
      #1;
      if (bus.mem_ready || !bus.mem_req) begin
         wait_cnt   = 0;
         beat_stall = $urandom_range(stall_hi, stall_lo);
      end
      if (!bus.mem_req) bus.mem_ready = 1'b0;
      else if (wait_cnt >= beat_stall) begin
         bus.mem_ready = 1'b1;
         bus.mem_rdata = mem_read(bus.mem_addr);
      end else begin
         bus.mem_ready = 1'b0;
         wait_cnt++;
         stall_total++;
      end
   end

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } xfer_t;

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] data;
   } wr_t;

   xfer_t xq[$];
   wr_t   wq[$];

   logic        prev_stall = 1'b0;
   logic [31:0] sv_addr, sv_wdata;
   logic        sv_we;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_reg(input logic [3:0] i, input logic [31:0] v);
      @(negedge clk);
      tb_we = 1'b1; tb_waddr = i; tb_wdata = v;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // Called once per cycle at the falling edge while a command is in flight.
   task automatic mon_step();
      xfer_t e;
      wr_t   w;
      if (prev_stall && bus.mem_req) begin
         chk("stall_addr_stable", bus.mem_addr, sv_addr);
         chk("stall_we_stable", bus.mem_we, sv_we);
         chk("stall_wdata_stable", bus.mem_wdata, sv_wdata);
      end
      prev_stall = bus.mem_req && !bus.mem_ready;
      sv_addr = bus.mem_addr; sv_we = bus.mem_we; sv_wdata = bus.mem_wdata;
      if (bus.mem_req && bus.mem_ready) begin
         if (xq.size() == 0) chk("xfer_unexpected", bus.mem_req && bus.mem_ready, 0);
         else begin
            e = xq.pop_front();
            chk("xfer_addr", bus.mem_addr, e.addr);
            chk("xfer_we", bus.mem_we, e.we);
            if (e.we) chk("xfer_wdata", bus.mem_wdata, e.data);
         end
      end
      if (bus.rf_we) begin
         if (wq.size() == 0) chk("rf_we_unexpected", bus.rf_we, 0);
         else begin
            w = wq.pop_front();
            chk("rf_waddr", bus.rf_waddr, w.idx);
            chk("rf_wdata", bus.rf_wdata, w.data);
         end
      end
   endtask

   task automatic run_cmd(input logic ld, input logic db, input logic wb, input logic [3:0] base,
                          input logic [15:0] list, output int unsigned cyc, output logic err_seen);
      logic [31:0] m_rf [16];
      logic [31:0] b, st, fin, a, d;
      int unsigned n, k, s0, exp_cyc;
      logic        wb_hit, got;
      for (int i = 0; i < 16; i++) m_rf[i] = rf[i];
      n   = $countones(list);
      b   = m_rf[base];
      st  = db ? b - 4 * n : b;
      fin = db ? b - 4 * n : b + 4 * n;
      k   = 0;
      xq.delete(); wq.delete();
      for (int i = 0; i < 16; i++) begin
         if (list[i]) begin
            a = st + 4 * k;
            if (!ld) xq.push_back('{addr: a, we: 1'b1, data: m_rf[i]});
            else begin
               d = mem_read(a);
               xq.push_back('{addr: a, we: 1'b0, data: 32'h0});
               wq.push_back('{idx: 4'(i), data: d});
               m_rf[i] = d;
            end
            k++;
         end
      end
      wb_hit = (n != 0) && wb && !(ld && list[base]);
      if (wb_hit) begin
         wq.push_back('{idx: base, data: fin});
         m_rf[base] = fin;
      end

      s0 = stall_total;
      prev_stall = 1'b0;
      cyc = 0; err_seen = 1'b0; got = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.is_load = ld; bus.dec_before = db;
      bus.writeback = wb; bus.base_reg = base; bus.reg_list = list;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int t = 0; t < 400 && !got; t++) begin
         @(negedge clk);
         cyc++;
         mon_step();
         if (cyc == 1) chk("busy_in_base", bus.busy, 1);
         if (cyc == 2 && n != 0) chk("mem_req_cycle2", bus.mem_req, 1);
         if (bus.done) begin
            got = 1'b1;
            err_seen = bus.err;
         end
      end
      if (!got) chk("done_timeout", bus.done, 1);
      exp_cyc = (n == 0) ? 2 : 2 + n + (wb_hit ? 1 : 0) + (stall_total - s0);
      chk("done_cycle_model", cyc, exp_cyc);
      chk("err_model", err_seen, (n == 0));
      @(negedge clk);
      mon_step();
      chk("idle_after_done", bus.busy, 0);
      chk("done_one_cycle", bus.done, 0);
      chk("xfers_outstanding", xq.size(), 0);
      chk("writes_outstanding", wq.size(), 0);
      for (int i = 0; i < 16; i++) chk($sformatf("rf_final_r%0d", i), rf[i], m_rf[i]);
   endtask

   task automatic reset_mid();
      logic seen;
      seen = 1'b0;
      stall_lo = 8; stall_hi = 8;
      set_reg(4'd3, 32'h0000_3000);
      xq.delete(); wq.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.is_load = 1'b0; bus.dec_before = 1'b0;
      bus.writeback = 1'b1; bus.base_reg = 4'd3; bus.reg_list = 16'h00F0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         mon_step();
         seen = bus.mem_req;
      end
      chk("rst_mid_in_xfer", bus.mem_req, 1);
      repeat (2) begin
         @(negedge clk);
         mon_step();
      end
      rst_n = 1'b0;
      @(negedge clk);
      mon_step();
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_mem_req", bus.mem_req, 0);
      chk("rst_mid_rf_we", bus.rf_we, 0);
      chk("rst_mid_done", bus.done, 0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         mon_step();
         chk("post_rst_done", bus.done, 0);
         chk("post_rst_busy", bus.busy, 0);
      end
   endtask

   typedef struct {
      logic        ld, db, wb;
      logic [3:0]  base;
      logic [15:0] list;
      logic [31:0] base_val;
      int unsigned stall;
      int unsigned exp_cyc;
      logic        exp_err;
      logic [31:0] exp_base;
   } vec_t;

   vec_t vt[6];

   initial begin
      int unsigned cyc;
      logic        e;
      logic [15:0] lst;

      // ld db wb base list base_val stall cycle err base-after
      vt[0] = '{1'b0, 1'b0, 1'b1, 4'd0,  16'h0006, 32'h0000_1000, 0, 5, 1'b0, 32'h0000_1008};
      vt[1] = '{1'b0, 1'b1, 1'b1, 4'd13, 16'h4010, 32'h0000_2000, 0, 5, 1'b0, 32'h0000_1FF8};
      // 2 wait states per beat: 2 + 2 beats + 4 stalls + WB
      vt[2] = '{1'b1, 1'b0, 1'b1, 4'd13, 16'h8010, 32'h0000_1FF8, 2, 9, 1'b0, 32'h0000_2000};
      vt[3] = '{1'b0, 1'b0, 1'b1, 4'd5,  16'h0000, 32'h0000_1234, 0, 2, 1'b1, 32'h0000_1234};
      vt[4] = '{1'b1, 1'b0, 1'b1, 4'd2,  16'h0004, 32'h0000_0100, 0, 3, 1'b0, 32'h0000_0055};
      vt[5] = '{1'b0, 1'b0, 1'b0, 4'd4,  16'h0003, 32'hFFFF_FFFC, 0, 4, 1'b0, 32'hFFFF_FFFC};

      mem[32'h0000_1FF8] = 32'h0000_00AA;
      mem[32'h0000_1FFC] = 32'h0000_00BB;
      mem[32'h0000_0100] = 32'h0000_0055;

      bus.start = 1'b0; bus.is_load = 1'b0; bus.dec_before = 1'b0;
      bus.writeback = 1'b0; bus.base_reg = '0; bus.reg_list = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_rf_we", bus.rf_we, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_rf_raddr", bus.rf_raddr, 0);
      chk("rst_rf_waddr", bus.rf_waddr, 0);
      chk("rst_rf_wdata", bus.rf_wdata, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);

      for (int v = 0; v < 6; v++) begin
         if (v == 5) reset_mid();
         stall_lo = vt[v].stall; stall_hi = vt[v].stall;
         set_reg(vt[v].base, vt[v].base_val);
         run_cmd(vt[v].ld, vt[v].db, vt[v].wb, vt[v].base, vt[v].list, cyc, e);
         chk($sformatf("vec%0d_done_cycle", v), cyc, vt[v].exp_cyc);
         chk($sformatf("vec%0d_err", v), e, vt[v].exp_err);
         chk($sformatf("vec%0d_base_after", v), rf[vt[v].base], vt[v].exp_base);
         if (v == 2) begin
            chk("pop_r4", rf[4], 32'h0000_00AA);
            chk("pop_r15", rf[15], 32'h0000_00BB);
         end
      end

      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);
         stall_lo = 0;
         stall_hi = $urandom_range(2, 0);
         lst = ($urandom_range(7, 0) == 0) ? 16'h0000 : 16'($urandom);
         bus.base_reg = 4'($urandom);
         set_reg(bus.base_reg, ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC));
         run_cmd(1'($urandom), 1'($urandom), 1'($urandom), bus.base_reg, lst, cyc, e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
